// File: rtl/jpeg_pkg.sv
// Shared constants, zigzag table, token layout and read-FSM encoding for the
// zigzag/run-length stage of the JPEG encoder.
package jpeg_pkg;

    localparam int CW = 9;   // quantised coefficient width (signed)
    localparam int LW = 10;  // token level width (signed, holds DC difference)
    localparam int RW = 4;   // token run width

    localparam logic [RW-1:0] ZRL_RUN   = 4'd15;
    localparam logic [RW-1:0] EOB_RUN   = '0;
    localparam logic [LW-1:0] EOB_LEVEL = '0;

    // Zigzag scan position k -> raster index (row*8+col).
    localparam logic [5:0] ZZ_ROM [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DC,
        S_SCAN,
        S_ZRL,
        S_EOB,
        S_DONE
    } rd_state_e;

    typedef struct packed {
        logic          dc;
        logic          eob;
        logic [RW-1:0] run;
        logic [LW-1:0] level;
    } token_t;

    function automatic logic [LW-1:0] sext_coef(input logic [CW-1:0] c);
        return {{(LW-CW){c[CW-1]}}, c};
    endfunction

endpackage

// File: rtl/zz_bank_ram.sv
// Ping-pong coefficient store: two 64-entry banks, one write port, one
// synchronous read port (data appears the cycle after the address).
module zz_bank_ram
    import jpeg_pkg::*;
#(
    parameter int W = CW
)
(
    input  logic         clk,
    input  logic         we,
    input  logic         wbank,
    input  logic [5:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic         rbank,
    input  logic [5:0]   raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem_q [128];
    logic [W-1:0] rdata_q;

    // NOTE: storage arrays carry no reset; contents are only read after a
    // whole block has been written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[{wbank, waddr}] <= wdata;
        end
        rdata_q <= mem_q[{rbank, raddr}];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/zigzag_rle.sv
// Captures 8x8 quantised blocks into a ping-pong buffer and emits JPEG
// run/level tokens in zigzag order. Define DC_DIFF_EN for differential DC.
module zigzag_rle
    import jpeg_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] dctq,
    input  logic          dctq_valid,
    input  logic [5:0]    addr,
    input  logic          dc_clr,
    output logic          hold,
    output logic          ovf,
    output logic          rle_valid,
    input  logic          out_ready,
    output logic [RW-1:0] rle_run,
    output logic [LW-1:0] rle_level,
    output logic          rle_dc,
    output logic          rle_eob
);

    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic          hold_q, hold_d;
    logic          ovf_q, ovf_d;
    rd_state_e     state_q, state_d;
    logic [5:0]    k_q, k_d;
    logic [5:0]    run_q, run_d;
    token_t        tok_q, tok_d;
    logic          tok_valid_q, tok_valid_d;

    logic          wr_en;
    logic          slot_free;
    logic [CW-1:0] coef;
    logic [LW-1:0] dc_level;

`ifdef DC_DIFF_EN
    logic [CW-1:0] pred_q, pred_d;
    logic [CW-1:0] dc_coef_q, dc_coef_d;
`else
    logic          unused_dc_clr;
    assign unused_dc_clr = dc_clr;
`endif

    assign wr_en = dctq_valid && !hold_q;

    zz_bank_ram #(.W(CW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .wbank (wbank_q),
        .waddr (addr),
        .wdata (dctq),
        .rbank (rbank_q),
        .raddr (ZZ_ROM[k_d]),
        .rdata (coef)
    );

`ifdef DC_DIFF_EN
    assign dc_level = sext_coef(coef) - sext_coef(pred_q);
`else
    assign dc_level = sext_coef(coef);
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        full_d      = full_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        ovf_d       = ovf_q | (dctq_valid & hold_q);
        state_d     = state_q;
        k_d         = k_q;
        run_d       = run_q;
        tok_d       = tok_q;
        tok_valid_d = tok_valid_q & ~out_ready;
        slot_free   = !tok_valid_q || out_ready;
`ifdef DC_DIFF_EN
        dc_coef_d   = dc_coef_q;
        pred_d      = pred_q;
        if (tok_valid_q && out_ready && tok_q.dc) begin
            pred_d = dc_coef_q;
        end
        if (dc_clr) begin
            pred_d = '0;
        end
`endif

        if (wr_en && addr == 6'd63) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end

        // k_q always names the coefficient currently on the RAM output; the
        // read address follows k_d so a stalled scan keeps re-reading it.
        unique case (state_q)
            S_IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d = S_FETCH;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                state_d = S_DC;
            end
            S_DC: begin
                if (slot_free) begin
                    tok_valid_d = 1'b1;
                    tok_d       = '0;
                    tok_d.dc    = 1'b1;
                    tok_d.level = dc_level;
`ifdef DC_DIFF_EN
                    dc_coef_d   = coef;
`endif
                    run_d       = '0;
                    k_d         = 6'd1;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN, S_ZRL: begin
                if (slot_free) begin
                    if (coef == '0) begin
                        run_d = run_q + 6'd1;
                        if (k_q == 6'd63) begin
                            state_d = S_EOB;
                        end else begin
                            k_d     = k_q + 6'd1;
                            state_d = S_SCAN;
                        end
                    end else if (run_q > 6'd15) begin
                        tok_valid_d = 1'b1;
                        tok_d       = '0;
                        tok_d.run   = ZRL_RUN;
                        run_d       = run_q - 6'd16;
                        state_d     = S_ZRL;
                    end else begin
                        tok_valid_d = 1'b1;
                        tok_d       = '0;
                        tok_d.run   = run_q[RW-1:0];
                        tok_d.level = sext_coef(coef);
                        run_d       = '0;
                        if (k_q == 6'd63) begin
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q + 6'd1;
                            state_d = S_SCAN;
                        end
                    end
                end
            end
            S_EOB: begin
                if (slot_free) begin
                    tok_valid_d = 1'b1;
                    tok_d       = '0;
                    tok_d.eob   = 1'b1;
                    tok_d.run   = EOB_RUN;
                    tok_d.level = EOB_LEVEL;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                k_d             = '0;
                state_d         = full_q[~rbank_q] ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hold_d = full_d[wbank_d];
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            hold_q      <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            k_q         <= '0;
            run_q       <= '0;
            tok_q       <= '0;
            tok_valid_q <= 1'b0;
`ifdef DC_DIFF_EN
            pred_q      <= '0;
            dc_coef_q   <= '0;
`endif
        end else begin
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            hold_q      <= hold_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            k_q         <= k_d;
            run_q       <= run_d;
            tok_q       <= tok_d;
            tok_valid_q <= tok_valid_d;
`ifdef DC_DIFF_EN
            pred_q      <= pred_d;
            dc_coef_q   <= dc_coef_d;
`endif
        end
    end

    assign hold      = hold_q;
    assign ovf       = ovf_q;
    assign rle_valid = tok_valid_q;
    assign rle_run   = tok_q.run;
    assign rle_level = tok_q.level;
    assign rle_dc    = tok_q.dc;
    assign rle_eob   = tok_q.eob;

endmodule

// File: tb/tb_zigzag_rle.sv
// Scoreboard bench for zigzag_rle: a reference tokeniser fills the expected
// queue as blocks are written; accepted tokens are popped and compared.
module tb_zigzag_rle;
    import jpeg_pkg::*;

    typedef logic signed [CW-1:0] blk_t [64];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] dctq = '0;
    logic          dctq_valid = 1'b0;
    logic [5:0]    addr = '0;
    logic          dc_clr = 1'b0;
    logic          hold, ovf, rle_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] rle_run;
    logic [LW-1:0] rle_level;
    logic          rle_dc, rle_eob;

    zigzag_rle dut (
        .clk        (clk),
        .reset      (reset),
        .dctq       (dctq),
        .dctq_valid (dctq_valid),
        .addr       (addr),
        .dc_clr     (dc_clr),
        .hold       (hold),
        .ovf        (ovf),
        .rle_valid  (rle_valid),
        .out_ready  (out_ready),
        .rle_run    (rle_run),
        .rle_level  (rle_level),
        .rle_dc     (rle_dc),
        .rle_eob    (rle_eob)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    int          zz [64];
    int          pred = 0;
    int          cyc = 0;
    int          stall_from = 0;
    int          stall_len = 0;
    bit          saw_hold = 0;
    logic [15:0] prev_tok;
    logic [15:0] exp_tok;
    bit          have_prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tok(input bit dc, input bit eob, input int run, input int level);
        logic [3:0] r4;
        logic [9:0] l10;
        r4  = 4'(run);
        l10 = 10'(level);
        return {dc, eob, r4, l10};
    endfunction

    // Reference tokeniser for one block; keeps its own DC predictor.
    task automatic push_block(input blk_t b);
        int run = 0;
        int c;
        int lvl;
        lvl = int'(b[zz[0]]);
`ifdef DC_DIFF_EN
        lvl  = lvl - pred;
        pred = int'(b[zz[0]]);
`endif
        exp_q.push_back(tok(1, 0, 0, lvl));
        for (int k = 1; k < 64; k++) begin
            c = int'(b[zz[k]]);
            if (c == 0) begin
                run++;
            end else begin
                while (run > 15) begin
                    exp_q.push_back(tok(0, 0, 15, 0));
                    run -= 16;
                end
                exp_q.push_back(tok(0, 0, run, c));
                run = 0;
            end
        end
        if (run > 0) exp_q.push_back(tok(0, 1, 0, 0));
    endtask

    // Writes a block in raster order, waiting out hold; optionally pokes one
    // illegal write (addr 63, value 77) into the first hold cycle.
    task automatic send_block(input blk_t b, input bit force_ovf);
        int guard;
        bit forced = 0;
        push_block(b);
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            guard = 0;
            while (hold && guard < 1000) begin
                saw_hold = 1;
                if (force_ovf && !forced) begin
                    forced     = 1;
                    dctq_valid = 1'b1;
                    addr       = 6'd63;
                    dctq       = 9'd77;
                end else begin
                    dctq_valid = 1'b0;
                end
                @(negedge clk);
                guard++;
            end
            if (hold) check("hold_stuck", hold, 0);
            dctq_valid = 1'b1;
            addr       = 6'(a);
            dctq       = b[a];
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        @(negedge clk);
        dctq_valid = 1'b0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, rle_valid, 0);
        check({tag, "_run"},   rle_run,   0);
        check({tag, "_level"}, rle_level, 0);
        check({tag, "_dc"},    rle_dc,    0);
        check({tag, "_eob"},   rle_eob,   0);
        check({tag, "_hold"},  hold,      0);
        check({tag, "_ovf"},   ovf,       0);
    endtask

    function automatic blk_t rand_block(input int nz_pct);
        blk_t b;
        int   v;
        for (int i = 0; i < 64; i++) begin
            v = int'($urandom_range(1, 200));
            if ($urandom_range(0, 1) == 1) v = -v;
            if (int'($urandom_range(0, 99)) >= nz_pct) v = 0;
            b[i] = 9'(v);
        end
        return b;
    endfunction

    // Monitor: owns out_ready, checks stall stability and scores accepted tokens.
    always @(negedge clk) begin
        cyc++;
        out_ready = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);
        if (reset) begin
            have_prev = 0;
        end else begin
            if (have_prev) begin
                check("stall_valid", rle_valid, 1);
                check("stall_tok", {rle_dc, rle_eob, rle_run, rle_level}, prev_tok);
            end
            have_prev = 0;
            if (rle_valid) begin
                if (!out_ready) begin
                    have_prev = 1;
                    prev_tok  = {rle_dc, rle_eob, rle_run, rle_level};
                end else if (exp_q.size() == 0) begin
                    check("extra_tok_qsize", exp_q.size(), 1);
                end else begin
                    exp_tok = exp_q.pop_front();
                    check("tok", {rle_dc, rle_eob, rle_run, rle_level}, exp_tok);
                end
            end
        end
    end

    initial begin
        blk_t b;
        blk_t zero;
        int   idx = 0;
        int   n;
        int   guard;

        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) zz[idx++] = r * 8 + (s - r);
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) zz[idx++] = r * 8 + (s - r);
            end
        end
        for (int i = 0; i < 64; i++) zero[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // 1: all-zero AC, DC 5
        b = zero; b[0] = 9'sd5;
        send_block(b, 0);
        drain(400);
        repeat (5) @(negedge clk);
        check("t1_idle_valid", rle_valid, 0);
        check("t1_idle_hold", hold, 0);

        // 2: DC 3 (differential against 5 when enabled)
        b = zero; b[0] = 9'sd3;
        send_block(b, 0);
        drain(400);

        // 3: clear predictor, then -1 at k=1 and 7 at k=20
        @(negedge clk); dc_clr = 1'b1;
        @(negedge clk); dc_clr = 1'b0;
        pred = 0;
        b = zero; b[zz[1]] = -9'sd1; b[zz[20]] = 9'sd7;
        send_block(b, 0);
        drain(400);

        // 4: only the last zigzag position set: three ZRLs, no EOB
        b = zero; b[63] = -9'sd4;
        send_block(b, 0);
        drain(400);

        // 5: three blocks back-to-back, 5-cycle output stall, write during hold
        saw_hold = 0;
        b = rand_block(100); b[63] = -9'sd100;
        send_block(b, 0);
        stall_from = cyc + 4;
        stall_len  = 5;
        send_block(rand_block(15), 0);
        send_block(rand_block(40), 1);
        check("t5_saw_hold", saw_hold, 1);
        check("t5_ovf", ovf, 1);
        drain(2000);
        stall_len = 0;

        // 6: reset mid-scan, then a fresh block with DC 9
        b = rand_block(100);
        send_block(b, 0);
        @(negedge clk); dctq_valid = 1'b0;
        n = exp_q.size();
        guard = 0;
        while (exp_q.size() >= n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() >= n) check("t6_first_tok_qsize", exp_q.size(), n - 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        exp_q.delete();
        pred = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); dc_clr = 1'b1;
        @(negedge clk); dc_clr = 1'b0;
        b = zero; b[0] = 9'sd9;
        send_block(b, 0);
        drain(400);
        repeat (5) @(negedge clk);
        check("t6_idle_valid", rle_valid, 0);
        check("t6_idle_hold", hold, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
